// File: rtl/mux_nx_reg.sv
// Registered N-channel, W-bit selector with latched manual select and auto-scan.
// Define MUX_HOLD_EN to add a hold input that freezes the datapath, select and dwell count.
module mux_nx_reg #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 8,
  parameter int unsigned SEL_W    = 3,
  parameter int unsigned DWELL    = 4
) (
  input  logic                      clk,
  input  logic                      rst,
`ifdef MUX_HOLD_EN
  input  logic                      hold,
`endif
  input  logic [CHANNELS*WIDTH-1:0] in_bus,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      load,
  input  logic                      mode,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_valid,
  output logic [SEL_W-1:0]          cur_sel,
  output logic                      sel_err,
  output logic                      scan_wrap
);

  localparam int unsigned CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DWELL - 1);
  localparam logic [SEL_W-1:0] SEL_LAST  = SEL_W'(CHANNELS - 1);
  // One extra bit so CHANNELS == 2**SEL_W is representable.
  localparam logic [SEL_W:0]   SEL_LIMIT = (SEL_W + 1)'(CHANNELS);

  typedef enum logic [1:0] {IDLE, MANUAL, SCAN} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [SEL_W-1:0] sel_nxt;
  logic [WIDTH-1:0] data_nxt;
  logic             valid_nxt, err_nxt, wrap_nxt;
  logic             frz;

`ifdef MUX_HOLD_EN
  assign frz = hold;
`else
  assign frz = 1'b0;
`endif

  // State register and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      cur_sel   <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      sel_err   <= 1'b0;
      scan_wrap <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      cur_sel   <= sel_nxt;
      out_data  <= data_nxt;
      out_valid <= valid_nxt;
      sel_err   <= err_nxt;
      scan_wrap <= wrap_nxt;
    end
  end

  // Next-state, select, dwell and output logic.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    sel_nxt   = cur_sel;
    data_nxt  = out_data;
    valid_nxt = out_valid;
    err_nxt   = 1'b0;
    wrap_nxt  = 1'b0;

    unique case (state)
      IDLE:    state_nxt = mode ? SCAN : MANUAL;
      MANUAL:  state_nxt = mode ? SCAN : MANUAL;
      SCAN:    state_nxt = mode ? SCAN : MANUAL;
      default: state_nxt = IDLE;
    endcase

    if (!frz) begin
      data_nxt = in_bus[cur_sel*WIDTH +: WIDTH];
      // Counter is cleared on any edge that is not a scan step, covering entry and exit.
      cnt_nxt  = '0;
      if (state == MANUAL && !mode && load) begin
        if ({1'b0, sel} >= SEL_LIMIT) err_nxt = 1'b1;
        else                          sel_nxt = sel;
      end else if (state == SCAN && mode) begin
        if (cnt == CNT_LAST) begin
          wrap_nxt = (cur_sel == SEL_LAST);
          sel_nxt  = (cur_sel == SEL_LAST) ? '0 : cur_sel + 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      // Data lags cur_sel by one edge, so a select change costs one invalid cycle.
      valid_nxt = (state != IDLE) && (sel_nxt == cur_sel);
    end
  end

endmodule

// File: tb/tb_mux_nx_reg.sv
// Table-driven bench for mux_nx_reg: per-cycle expectations queued at drive time, popped after the edge.
module tb_mux_nx_reg;

  localparam int unsigned WIDTH    = 8;
  localparam int unsigned CHANNELS = 8;
  localparam int unsigned SEL_W    = 4;
  localparam int unsigned DWELL    = 4;

  logic                      clk = 1'b0;
  logic                      rst = 1'b0;
`ifdef MUX_HOLD_EN
  logic                      hold = 1'b0;
`endif
  logic [CHANNELS*WIDTH-1:0] in_bus;
  logic [SEL_W-1:0]          sel;
  logic                      load;
  logic                      mode;
  logic [WIDTH-1:0]          out_data;
  logic                      out_valid;
  logic [SEL_W-1:0]          cur_sel;
  logic                      sel_err;
  logic                      scan_wrap;

  mux_nx_reg #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .SEL_W(SEL_W), .DWELL(DWELL)) dut (
    .clk(clk),
    .rst(rst),
`ifdef MUX_HOLD_EN
    .hold(hold),
`endif
    .in_bus(in_bus),
    .sel(sel),
    .load(load),
    .mode(mode),
    .out_data(out_data),
    .out_valid(out_valid),
    .cur_sel(cur_sel),
    .sel_err(sel_err),
    .scan_wrap(scan_wrap)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [SEL_W-1:0] sel;
    logic [WIDTH-1:0] data;
    logic             valid;
    logic             err;
    logic             wrap;
  } exp_t;

  typedef struct {
    logic             rst_before;
    logic             chg;
    logic             mode;
    logic             load;
    logic [SEL_W-1:0] sel;
    exp_t             e;
  } row_t;

  row_t tbl[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic check_out(input string tag, input exp_t e);
    chk({tag, ".cur_sel"},   32'(cur_sel),   32'(e.sel));
    chk({tag, ".out_data"},  32'(out_data),  32'(e.data));
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(e.valid));
    chk({tag, ".sel_err"},   32'(sel_err),   32'(e.err));
    chk({tag, ".scan_wrap"}, 32'(scan_wrap), 32'(e.wrap));
  endtask

  task automatic add(input logic rb, input logic c, input logic m, input logic l, input int s,
                     input int es, input int ed, input logic ev, input logic ee, input logic ew);
    row_t r;
    r.rst_before = rb;
    r.chg        = c;
    r.mode       = m;
    r.load       = l;
    r.sel        = SEL_W'(s);
    r.e.sel      = SEL_W'(es);
    r.e.data     = WIDTH'(ed);
    r.e.valid    = ev;
    r.e.err      = ee;
    r.e.wrap     = ew;
    tbl.push_back(r);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t zero;
    exp_t e;
    zero = '{sel: '0, data: '0, valid: 1'b0, err: 1'b0, wrap: 1'b0};

    for (int k = 0; k < int'(CHANNELS); k++) in_bus[k*WIDTH +: WIDTH] = WIDTH'(k + 16);
    mode = 1'b0;
    load = 1'b0;
    sel  = '0;

    //  rb c  m  l  sel  | cur data valid err wrap
    add(0, 0, 0, 0, 0,   0, 'h10, 0, 0, 0);  // IDLE -> MANUAL
    add(0, 0, 0, 0, 0,   0, 'h10, 1, 0, 0);
    add(0, 0, 0, 1, 5,   5, 'h10, 0, 0, 0);  // load 5
    add(0, 0, 0, 0, 0,   5, 'h15, 1, 0, 0);
    add(0, 0, 0, 1, 3,   3, 'h15, 0, 0, 0);
    add(0, 0, 0, 0, 0,   3, 'h13, 1, 0, 0);
    add(0, 0, 0, 1, 9,   3, 'h13, 1, 1, 0);  // out-of-range select
    add(0, 0, 0, 0, 0,   3, 'h13, 1, 0, 0);
    add(0, 0, 0, 1, 3,   3, 'h13, 1, 0, 0);  // reload same channel
    add(0, 0, 0, 1, 6,   6, 'h13, 0, 0, 0);
    add(0, 0, 1, 0, 0,   6, 'h16, 1, 0, 0);  // enter SCAN
    add(0, 0, 1, 0, 0,   6, 'h16, 1, 0, 0);
    add(0, 0, 1, 0, 0,   6, 'h16, 1, 0, 0);
    add(0, 0, 1, 0, 0,   6, 'h16, 1, 0, 0);
    add(0, 0, 1, 0, 0,   7, 'h16, 0, 0, 0);
    add(0, 0, 1, 0, 0,   7, 'h17, 1, 0, 0);
    add(0, 0, 1, 1, 12,  7, 'h17, 1, 0, 0);  // load ignored in scan
    add(0, 0, 1, 0, 0,   7, 'h17, 1, 0, 0);
    add(0, 0, 1, 0, 0,   0, 'h17, 0, 0, 1);  // wrap
    add(0, 0, 1, 0, 0,   0, 'h10, 1, 0, 0);
    add(0, 0, 0, 0, 0,   0, 'h10, 1, 0, 0);  // leave SCAN
    add(0, 0, 0, 0, 0,   0, 'h10, 1, 0, 0);
    add(0, 0, 0, 1, 4,   4, 'h10, 0, 0, 0);
    add(0, 0, 0, 0, 0,   4, 'h14, 1, 0, 0);
    add(0, 0, 1, 0, 0,   4, 'h14, 1, 0, 0);
    add(0, 0, 1, 0, 0,   4, 'h14, 1, 0, 0);
    add(1, 0, 1, 0, 0,   0, 'h10, 0, 0, 0);  // async reset mid-scan, restart in SCAN
    add(0, 0, 1, 0, 0,   0, 'h10, 1, 0, 0);
    add(0, 0, 1, 0, 0,   0, 'h10, 1, 0, 0);
    add(0, 0, 1, 0, 0,   0, 'h10, 1, 0, 0);
    add(0, 0, 1, 0, 0,   1, 'h10, 0, 0, 0);
    add(0, 0, 1, 0, 0,   1, 'h11, 1, 0, 0);
    add(0, 1, 1, 0, 0,   1, 'hA5, 1, 0, 0);  // in_bus change on current channel
    add(0, 0, 0, 0, 0,   1, 'hA5, 1, 0, 0);

    #1 rst = 1'b1;
    #1 check_out("rst_async", zero);
    @(posedge clk); #1;
    check_out("rst_held", zero);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      row_t r;
      r = tbl[i];
      if (r.rst_before) begin
        #2 rst = 1'b1;
        #1 check_out("rst_mid", zero);
        @(negedge clk);
        rst = 1'b0;
      end
      mode = r.mode;
      load = r.load;
      sel  = r.sel;
      if (r.chg) in_bus[1*WIDTH +: WIDTH] = 8'hA5;
      sb.push_back(r.e);
      @(posedge clk); #1;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_empty row=%0d", i);
      end else begin
        e = sb.pop_front();
        check_out($sformatf("row%0d", i), e);
      end
      if (i + 1 < tbl.size() && !tbl[i+1].rst_before) @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_nx_reg.md
Name: mux_nx_reg

Overview:
- Parametrised, registered N-channel, W-bit selector.
- Successor to the team's fixed 8:1 single-bit combinational selector.
- Adds a latched select, an auto-scan mode that steps through channels with a programmable dwell time, output-valid signalling and out-of-range select detection.
- Sits between multi-channel sources and a single downstream consumer (display, serial link).

Parameters:
- WIDTH, 8: bits per channel.
- CHANNELS, 8: number of input channels, 2..256.
- SEL_W, 3: select width; must satisfy 2**SEL_W >= CHANNELS.
- DWELL, 4: cycles spent on each channel in scan mode, >= 1.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_bus  input  CHANNELS*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- sel  input  SEL_W  requested channel in manual mode.
- load  input  1  latch sel into cur_sel (manual mode only).
- mode  input  1  0 = manual, 1 = scan.
- out_data  output  WIDTH  registered selected channel data.
- out_valid  output  1  out_data reflects cur_sel and is stable.
- cur_sel  output  SEL_W  currently selected channel.
- sel_err  output  1  one-cycle pulse: load attempted with sel >= CHANNELS.
- scan_wrap  output  1  one-cycle pulse when scan advances from CHANNELS-1 to 0.

Behaviour:
- Reset (async, active-high) forces:
  - out_data=0, out_valid=0, cur_sel=0, sel_err=0, scan_wrap=0, dwell counter=0, state=IDLE.
  - Reset mid-scan or mid-load aborts immediately; there is no partial state.
- States:
  - IDLE: first cycle after reset release.
  - MANUAL.
  - SCAN.
- Transitions, evaluated every edge, mode sampled on every edge:
  - IDLE -> MANUAL if mode=0, else SCAN.
  - MANUAL -> SCAN when mode=1.
  - SCAN -> MANUAL when mode=0.
- Datapath, every edge outside reset: out_data <= in_bus slice at cur_sel (value before the edge). Output latency is 1 cycle from cur_sel.
- Manual load:
  - load=1 with sel < CHANNELS at edge k: cur_sel=sel after edge k; out_data shows the new channel after edge k+1.
  - load=1 with sel >= CHANNELS: cur_sel unchanged; sel_err=1 for one cycle.
  - load=1 with sel equal to cur_sel: no change; out_valid stays high.
- Scan:
  - Entering SCAN clears the dwell counter and keeps cur_sel.
  - The counter increments each cycle. When it reaches DWELL-1 it clears and cur_sel advances by 1.
  - From CHANNELS-1, cur_sel wraps to 0 and scan_wrap=1 for that cycle.
  - DWELL=1 advances every cycle.
- load is ignored in SCAN: mode has priority, and sel_err is not raised.
- Leaving SCAN freezes cur_sel at its current value and clears the dwell counter.
- out_valid:
  - Low in IDLE.
  - Low for the cycle after any cur_sel change (one-cycle bubble while out_data catches up).
  - High otherwise.
  - With DWELL=1 in SCAN it stays low.
- in_bus changes with no cur_sel change: out_data follows with 1-cycle latency; out_valid stays high.

Optional Feature:
- MUX_HOLD_EN defined:
  - Adds input port hold (1 bit).
  - While hold=1: out_data, cur_sel, the dwell counter and out_valid are frozen; load is ignored with no sel_err; no scan_wrap is generated.
  - Mode transitions still update state, but take effect on data only after hold drops.
- Not defined: no hold port; behaviour as above.

Test Plan:
- Reset release, mode=0, channel k holds value k+0x10 for all k -> out_data=0x10 after 2 edges; out_valid=0 on cycle 1, 1 from cycle 2; cur_sel=0.
- Manual load sel=5 at edge k -> cur_sel=5 after edge k; out_valid=0 for one cycle; out_data=0x15 with out_valid=1 after edge k+1.
- load sel=9 with CHANNELS=8 while cur_sel=3 -> sel_err pulse 1 cycle; cur_sel stays 3; out_data stays 0x13.
- mode=1, DWELL=4, start cur_sel=6 -> cur_sel 6 for 4 cycles, then 7 for 4 cycles, then 0 with scan_wrap=1 for exactly 1 cycle.
- Async rst asserted mid-scan at cur_sel=4 (not edge-aligned) -> all outputs 0 immediately; after release, IDLE then state per mode, starting from cur_sel=0.
- With MUX_HOLD_EN: scan DWELL=2, hold=1 for 5 cycles at cur_sel=2 -> cur_sel and out_data frozen at 0x12; resumes the remaining dwell count after hold drops.
